// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: latches an operation, evaluates one bit per clock (LSB first),
// threads carry between steps and presents the word and flags on a valid/ready handshake.
module serial_alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MOVA = 3'b000;
    localparam logic [2:0] OP_NOTA = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_MOVB = 3'b111;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_result_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_zero;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic [WIDTH-1:0]   r_res_sh;

    logic [1:0]         w_slice;
    logic               w_bit;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // One-bit slice: returns {carry_out, result_bit}; carry_out is 0 for non-arithmetic ops.
    function automatic logic [1:0] alu_bit(input logic [2:0] f_op, input logic f_a,
                                           input logic f_b, input logic f_c);
        logic f_bx;
        logic [1:0] f_out;
        f_bx  = (f_op == OP_SUB) ? ~f_b : f_b;
        f_out = 2'b00;
        case (f_op)
            OP_MOVA: f_out = {1'b0, f_a};
            OP_NOTA: f_out = {1'b0, ~f_a};
            OP_AND:  f_out = {1'b0, f_a & f_b};
            OP_OR:   f_out = {1'b0, f_a | f_b};
            OP_XOR:  f_out = {1'b0, f_a ^ f_b};
            OP_ADD,
            OP_SUB:  f_out = {(f_a & f_bx) | (f_a & f_c) | (f_bx & f_c), f_a ^ f_bx ^ f_c};
            OP_MOVB: f_out = {1'b0, f_b};
            default: f_out = 2'b00;
        endcase
        return f_out;
    endfunction

    always_comb begin
        w_slice    = alu_bit(r_op, r_a[0], r_b[0], r_c);
        w_bit      = w_slice[0];
        w_cout     = w_slice[1];
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
        w_res_next = {w_bit, r_res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b1;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_carry        <= 1'b0;
            r_zero         <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_cnt          <= '0;
            r_c            <= 1'b0;
            r_res_sh       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op;
                        r_cnt      <= '0;
                        r_c        <= (op == OP_SUB);
                        r_res_sh   <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res_sh <= w_res_next;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_c      <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Published outputs only change here, so they hold across DONE and IDLE.
                    if (w_last) begin
                        r_state        <= S_DONE;
                        r_busy         <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_result       <= w_res_next;
                        r_carry        <= w_cout;
                        r_zero         <= (w_res_next == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_in_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign result       = r_result;
    assign carry        = r_carry;
    assign zero         = r_zero;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: hand-computed results, latency, backpressure and reset abort.
module tb_serial_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       result_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int n;

    serial_alu_sequencer #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
    endtask

    // Accepts one op, scrambles the inputs right after acceptance, then checks and drains the result.
    task automatic run_op(input string tag, input logic [2:0] v_op, input logic [7:0] v_a,
                          input logic [7:0] v_b, input logic [7:0] e_res,
                          input logic e_c, input logic e_z);
        in_valid = 1'b1;
        op = v_op;
        a  = v_a;
        b  = v_b;
        step();
        in_valid = 1'b0;
        op = ~v_op;
        a  = ~v_a;
        b  = ~v_b;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_low"}, in_ready, 0);
        wait_valid(tag, 8);
        chk({tag, "_result"}, result, e_res);
        chk({tag, "_carry"}, carry, e_c);
        chk({tag, "_zero"}, zero, e_z);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, result_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_hold_result"}, result, e_res);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'b000;
        a = 8'h00;
        b = 8'h00;
        step();
        step();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        step();
        chk("idle_hold_ready", in_ready, 1);
        chk("idle_hold_busy", busy, 0);

        run_op("add_ff_01", 3'b101, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run_op("sub_05_07", 3'b110, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run_op("sub_07_05", 3'b110, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
        run_op("mova", 3'b000, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0);
        run_op("nota", 3'b001, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0);
        run_op("and", 3'b010, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0);
        run_op("or", 3'b011, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0);
        run_op("xor", 3'b100, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0);
        run_op("movb", 3'b111, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0);
        run_op("and_opchg", 3'b010, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0);

        // Backpressure: hold the result while a new request waits.
        in_valid = 1'b1;
        op = 3'b101;
        a = 8'h10;
        b = 8'h20;
        step();
        in_valid = 1'b0;
        wait_valid("bp_add", 8);
        in_valid = 1'b1;
        op = 3'b111;
        a = 8'h00;
        b = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_result_stable", result, 8'h30);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_valid_held", result_valid, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", result_valid, 0);
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_not_busy", busy, 0);
        step();
        in_valid = 1'b0;
        chk("bp_new_accept_busy", busy, 1);
        chk("bp_new_accept_ready", in_ready, 0);
        wait_valid("bp_movb", 8);
        chk("bp_movb_result", result, 8'h55);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-RUN after three bit steps.
        in_valid = 1'b1;
        op = 3'b101;
        a = 8'h0F;
        b = 8'h01;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_carry", carry, 0);
        chk("abort_zero", zero, 0);
        run_op("mova_after_abort", 3'b000, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
